// File: rtl/cdc_sync_bus_filter_pkg.sv
// Shared constants and helpers for the multi-channel level synchroniser
// (cdc_sync_bus_filter; optional glitch filter enabled by CDC_SYNC_FILTER_EN).
package cdc_pkg;

    localparam int CDC_MIN_STAGES = 2;

    // Bits needed for a counter that can hold 0..n.
    function automatic int cdc_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cdc_glitch_filter.sv
// Single-channel glitch filter: dout follows s only after s has differed for
// FILTER_CYCLES consecutive cycles. Used when CDC_SYNC_FILTER_EN is defined.
module cdc_glitch_filter
    import cdc_pkg::*;
#(
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clock,
    input  logic arst,
    input  logic s,
    output logic dout
);

    localparam int               CNT_W    = cdc_cnt_w(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             dout_next;

    always_comb begin
        // NOTE: both outputs get a default before any branch, so no path leaves one unassigned and no latch is inferred.
        cnt_next  = '0;
        dout_next = dout;
        if (s != dout) begin
            if (cnt == CNT_LAST) begin
                dout_next = s;
            end else begin
                cnt_next = cnt + CNT_ONE;
            end
        end
    end

    // A reset mid-count drops the partial count, so a pending change never lands.
    always_ff @(posedge clock or posedge arst) begin
        if (arst) begin
            cnt  <= '0;
            dout <= RESET_VAL;
        end else begin
            cnt  <= cnt_next;
            dout <= dout_next;
        end
    end

endmodule

// File: rtl/cdc_sync_bus_filter.sv
// WIDTH independent level synchronisers with rise/fall pulses; the per-channel
// glitch filter is built only when CDC_SYNC_FILTER_EN is defined.
module cdc_sync_bus_filter
    import cdc_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clock,
    input  logic             arst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    generate
        if (STAGES < CDC_MIN_STAGES) begin : g_stages_chk
            $error("cdc_sync_bus_filter: STAGES=%0d is below the minimum of %0d", STAGES, CDC_MIN_STAGES);
        end
        if (FILTER_CYCLES < 1) begin : g_filter_chk
            $error("cdc_sync_bus_filter: FILTER_CYCLES=%0d must be at least 1", FILTER_CYCLES);
        end
    endgenerate

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clock or posedge arst) begin
        if (arst) begin
            // NOTE: every stage is reset, not only the output one; a stale bit deep in the chain would surface as a spurious edge after release.
            sync <= {STAGES{RESET_VAL}};
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's pre-edge value, giving a true STAGES-deep shift.
            sync <= {sync[STAGES-2:0], din};
        end
    end

    assign s = sync[STAGES-1];

`ifdef CDC_SYNC_FILTER_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_filter
        cdc_glitch_filter #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_filter (
            .clock (clock),
            .arst  (arst),
            .s     (s[i]),
            .dout  (dout[i])
        );
    end
`else
    assign dout = s;
`endif

    // dout_q resets to the same value as dout, so release never looks like an edge.
    always_ff @(posedge clock or posedge arst) begin
        if (arst) begin
            dout_q <= RESET_VAL;
        end else begin
            dout_q <= dout;
        end
    end

    assign rise = dout & ~dout_q;
    assign fall = ~dout & dout_q;

endmodule

// File: tb/tb_cdc_sync_bus_filter.sv
// Self-checking bench for cdc_sync_bus_filter; adapts its expectations to
// whether CDC_SYNC_FILTER_EN is defined.
`timescale 1ns/1ps
module tb_cdc_sync_bus_filter;

    localparam int         WIDTH         = 4;
    localparam int         FILTER_CYCLES = 4;
    localparam logic [3:0] RESET_VAL     = 4'b1010;
`ifdef CDC_SYNC_FILTER_EN
    localparam int STAGES = 2;
    localparam int LAT    = STAGES + FILTER_CYCLES;
`else
    localparam int STAGES = 3;
    localparam int LAT    = STAGES;
`endif

    logic             clock = 1'b0;
    logic             arst  = 1'b1;
    logic [WIDTH-1:0] din   = '0;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    cdc_sync_bus_filter #(
        .WIDTH         (WIDTH),
        .STAGES        (STAGES),
        .FILTER_CYCLES (FILTER_CYCLES),
        .RESET_VAL     (RESET_VAL)
    ) dut (
        .clock (clock),
        .arst  (arst),
        .din   (din),
        .dout  (dout),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: din samples taken at each edge, newest first.
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_dout;
    logic [WIDTH-1:0] m_rise;
    logic [WIDTH-1:0] m_fall;
`ifdef CDC_SYNC_FILTER_EN
    int run[WIDTH];
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_dout = RESET_VAL;
        m_rise = '0;
        m_fall = '0;
`ifdef CDC_SYNC_FILTER_EN
        for (int i = 0; i < WIDTH; i++) run[i] = 0;
`endif
    endtask

    // Level seen by the synchroniser output k edges ago is din sampled STAGES+k edges ago.
    task automatic model_edge();
        logic [WIDTH-1:0] new_dout;
        hist.push_front(din);
        if (hist.size() > STAGES + 1) void'(hist.pop_back());
`ifdef CDC_SYNC_FILTER_EN
        begin
            logic [WIDTH-1:0] s_prev;
            s_prev   = (hist.size() > STAGES) ? hist[STAGES] : RESET_VAL;
            new_dout = m_dout;
            for (int i = 0; i < WIDTH; i++) begin
                if (s_prev[i] != m_dout[i]) begin
                    run[i]++;
                    if (run[i] == FILTER_CYCLES) begin
                        new_dout[i] = s_prev[i];
                        run[i]      = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
`else
        new_dout = (hist.size() >= STAGES) ? hist[STAGES-1] : RESET_VAL;
`endif
        m_rise = new_dout & ~m_dout;
        m_fall = ~new_dout & m_dout;
        m_dout = new_dout;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("dout", dout, m_dout);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Assert reset mid-cycle, check its immediate effect, release at the next falling edge.
    task automatic pulse_reset();
        #2 arst = 1'b1;
        #1;
        model_reset();
        check("rst_dout", dout, RESET_VAL);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        @(negedge clock);
        arst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [WIDTH-1:0] mask;

        // Reset held across several edges.
        model_reset();
        din = RESET_VAL;
        #32;
        check("reset_dout", dout, RESET_VAL);
        check("reset_rise", rise, 0);
        check("reset_fall", fall, 0);
        @(negedge clock);
        arst = 1'b0;
        steps(LAT + 2);

        // Single-channel step latency.
        din = RESET_VAL | 4'b0001;
        lat = -1;
        for (int k = 1; k <= LAT + 4; k++) begin
            step();
            if (lat < 0 && dout[0] === 1'b1) lat = k;
        end
        check("latency_ch0", lat, LAT);

        // All channels step together while ch1 glitches for two cycles.
        din = 4'b0000;
        steps(LAT + 4);
        din = 4'b1111;
        steps(2);
        din = 4'b1101;
        steps(LAT + 4);

        // ch1: 3-cycle pulse, then a 4-cycle pulse.
        din = 4'b1111;
        steps(3);
        din = 4'b1101;
        steps(LAT + 3);
        din = 4'b1111;
        steps(4);
        din = 4'b1101;
        steps(LAT + 4);

        // ch2: single-cycle glitch.
        din = 4'b1001;
        steps(1);
        din = 4'b1101;
        steps(LAT + 3);

        // Reset while a change is part-way through the filter.
        din = RESET_VAL;
        steps(LAT + 3);
        din = ~RESET_VAL;
        steps(STAGES + 2);
        din = RESET_VAL;
        pulse_reset();
        steps(LAT + 3);
        check("discard_dout", dout, RESET_VAL);

        // Randomised quasi-static activity with occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < WIDTH; i++) mask[i] = ($urandom_range(0, 5) == 0);
            din = din ^ mask;
            step();
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
